sd_data_gen: RTL and testbench
==============================

SD_DATA_GEN -- requirements
Module: sd_data_gen

Interface
REQ-001 The block SHALL have parameter TEST_SEC_ADDR, default 32'd2000: the sector address used for both the write and the read-back.
REQ-002 The block SHALL have parameter SEC_WORDS, default 9'd256: the number of 16-bit words per 512-byte sector.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 24'd10_000_000: the maximum number of cycles allowed in each wait state.
REQ-004 The block SHALL have the following ports:
- clk  input  1: system clock; one clock, all logic on its rising edge.
- rst_n  input  1: reset, asynchronous and active-low.
- init_done  input  1: SD card initialisation complete, level.
- wr_start_en  output  1: one-cycle pulse that starts a sector write.
- wr_sec_addr  output  32: write sector address.
- wr_req  input  1: write controller consumes wr_data this cycle.
- wr_data  output  16: write word.
- wr_busy  input  1: write controller busy.
- rd_start_en  output  1: one-cycle pulse that starts a sector read.
- rd_sec_addr  output  32: read sector address.
- rd_busy  input  1: read controller busy.
- rd_val_en  input  1: rd_val_data valid this cycle.
- rd_val_data  input  16: read word.
- test_done  output  1: test finished, level.
- error_flag  output  1: test failed, level; consumed by the LED alarm stage.

Function
REQ-005 The block SHALL implement FSM states IDLE, WR_START, WR_WAIT, RD_START, RD_WAIT, CHECK and DONE.
REQ-006 The block SHALL register init_done once and detect its rising edge.
- IDLE -> WR_START on that rising edge only.
- A level already high out of reset SHALL count as a rising edge one cycle after reset release.
REQ-007 In WR_START the block SHALL:
- assert wr_start_en for exactly one cycle;
- clear the write word counter to 0;
- go to WR_WAIT next cycle.
REQ-008 wr_data SHALL equal the write word counter; each cycle with wr_req=1 SHALL increment the counter by 1 (16-bit, wrapping), so the sector holds 0,1,...,SEC_WORDS-1.
REQ-009 WR_WAIT -> RD_START on the first cycle where wr_busy=0 after wr_busy has been seen 1 in this state; a wr_busy low-to-high-to-low within the same cycle window SHALL NOT be assumed.
REQ-010 RD_START SHALL assert rd_start_en for exactly one cycle, clear the read word counter and match counter, then go to RD_WAIT.
REQ-011 In RD_WAIT, each cycle with rd_val_en=1 SHALL:
- compare rd_val_data with the read word counter;
- increment the match counter on equality;
- always increment the read word counter.
REQ-012 rd_val_en pulses beyond SEC_WORDS SHALL be ignored (counters saturate at SEC_WORDS).
REQ-013 RD_WAIT -> CHECK on the first rd_busy=0 after rd_busy has been seen 1 in this state.
REQ-014 CHECK SHALL last one cycle, then go to DONE.
- It SHALL set test_done=1.
- It SHALL set error_flag=1 iff match counter != SEC_WORDS or read word counter != SEC_WORDS.
REQ-015 DONE SHALL hold test_done and error_flag until init_done falls or reset; no retest without a new init_done rising edge.
REQ-016 A per-state cycle counter SHALL clear on every state change.
- Reaching TIMEOUT_CYC-1 in WR_WAIT or RD_WAIT SHALL force DONE with test_done=1 and error_flag=1 on the next cycle.
REQ-017 init_done=0 in any state other than IDLE SHALL return the FSM to IDLE next cycle.
- It SHALL clear all counters, test_done and error_flag.
- It SHALL suppress any start pulse that cycle.
REQ-018 wr_sec_addr and rd_sec_addr SHALL be driven constantly with TEST_SEC_ADDR.
REQ-019 wr_start_en and rd_start_en SHALL never be asserted in the same cycle and never for more than one cycle.

Reset
REQ-020 While rst_n=0 the block SHALL hold:
- state IDLE;
- wr_start_en=0, rd_start_en=0;
- wr_data=16'd0;
- test_done=0, error_flag=0;
- all counters at 0.
REQ-021 Reset assertion mid-write or mid-read SHALL take effect immediately (asynchronously) and abandon the test.

Verification
REQ-022 Bench SHALL cover these directed scenarios:
- Pass: init_done rises; the write model takes 256 wr_req; the read model returns 0..255 -> exactly one wr_start_en pulse, one rd_start_en pulse, then test_done=1, error_flag=0.
- Single corruption: read word 37 returned as 16'h0000 -> test_done=1, error_flag=1.
- Short read: read model gives only 255 rd_val_en then drops rd_busy -> error_flag=1; 257 pulses -> counters stop at 256, error_flag=0 if the first 256 match.
- Timeout: wr_busy never asserts after wr_start_en (TIMEOUT_CYC set to 100 in bench) -> DONE within 101 cycles, error_flag=1, rd_start_en never pulses.
- Abort: init_done drops during RD_WAIT -> IDLE next cycle, error_flag=0, test_done=0; init_done re-rises -> a fresh full test starts with wr_data=0.
- Reset: rst_n pulsed low during WR_WAIT -> all outputs at reset values within the same cycle; no start pulse until a new init_done rising edge.

Source files
------------

// File: rtl/sd_data_gen.sv
// SD card sector self-test sequencer.
// Writes one sector with an incrementing word pattern (0,1,2,...), reads the
// same sector back, and compares every returned word against its index.
// The outcome is reported as test_done / error_flag levels that stay valid
// until init_done falls or the block is reset.
module sd_data_gen #(
    parameter logic [31:0] TEST_SEC_ADDR = 32'd2000,
    parameter logic [8:0]  SEC_WORDS     = 9'd256,
    parameter logic [23:0] TIMEOUT_CYC   = 24'd10_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_done,
    output logic        wr_start_en,
    output logic [31:0] wr_sec_addr,
    input  logic        wr_req,
    output logic [15:0] wr_data,
    input  logic        wr_busy,
    output logic        rd_start_en,
    output logic [31:0] rd_sec_addr,
    input  logic        rd_busy,
    input  logic        rd_val_en,
    input  logic [15:0] rd_val_data,
    output logic        test_done,
    output logic        error_flag
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_START = 3'd1,
        WR_WAIT  = 3'd2,
        RD_START = 3'd3,
        RD_WAIT  = 3'd4,
        CHECK    = 3'd5,
        DONE     = 3'd6
    } state_t;

    state_t      state;
    logic        init_q;        // init_done delayed one cycle for edge detection
    logic        init_rise;
    logic [15:0] rd_cnt;        // words accepted from the read controller
    logic [15:0] match_cnt;     // accepted words equal to their index
    logic [23:0] state_cnt;     // cycles spent in the current state
    logic        wr_busy_seen;  // write controller has gone busy in WR_WAIT
    logic        rd_busy_seen;  // read controller has gone busy in RD_WAIT
    logic [15:0] sec_words_ext;
    logic        timeout_hit;
    logic        rd_accept;

    // The sector address never changes; both controllers see the same one.
    assign wr_sec_addr = TEST_SEC_ADDR;
    assign rd_sec_addr = TEST_SEC_ADDR;

    assign sec_words_ext = {7'd0, SEC_WORDS};
    // A level already high out of reset looks like an edge because init_q resets low.
    assign init_rise     = init_done & ~init_q;
    assign timeout_hit   = (state_cnt == TIMEOUT_CYC - 24'd1);
    // Pulses beyond one sector are dropped so both counters saturate at SEC_WORDS.
    assign rd_accept     = rd_val_en && (rd_cnt < sec_words_ext);

    // Test sequencer: state, counters and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every register, including the counters, is given a reset value here;
            // the block holds no memory array, so nothing is left without one.
            state        <= IDLE;
            init_q       <= 1'b0;
            wr_start_en  <= 1'b0;
            rd_start_en  <= 1'b0;
            wr_data      <= 16'd0;
            rd_cnt       <= 16'd0;
            match_cnt    <= 16'd0;
            state_cnt    <= 24'd0;
            wr_busy_seen <= 1'b0;
            rd_busy_seen <= 1'b0;
            test_done    <= 1'b0;
            error_flag   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; a later assignment to the
            // same register in this block overrides the defaults written just below.
            init_q      <= init_done;
            wr_start_en <= 1'b0;
            rd_start_en <= 1'b0;
            if (state_cnt != 24'hFF_FFFF) begin
                state_cnt <= state_cnt + 24'd1;
            end

            if (!init_done && (state != IDLE)) begin
                // Card lost its initialisation: abandon the test and forget the result.
                state        <= IDLE;
                wr_data      <= 16'd0;
                rd_cnt       <= 16'd0;
                match_cnt    <= 16'd0;
                state_cnt    <= 24'd0;
                wr_busy_seen <= 1'b0;
                rd_busy_seen <= 1'b0;
                test_done    <= 1'b0;
                error_flag   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (init_rise) begin
                            state       <= WR_START;
                            wr_start_en <= 1'b1;
                            wr_data     <= 16'd0;
                            state_cnt   <= 24'd0;
                        end
                    end

                    WR_START: begin
                        state        <= WR_WAIT;
                        wr_data      <= 16'd0;
                        wr_busy_seen <= 1'b0;
                        state_cnt    <= 24'd0;
                    end

                    WR_WAIT: begin
                        // wr_data is the word counter itself: the sector gets 0,1,2,...
                        if (wr_req) begin
                            wr_data <= wr_data + 16'd1;
                        end
                        if (wr_busy) begin
                            wr_busy_seen <= 1'b1;
                        end
                        if (wr_busy_seen && !wr_busy) begin
                            state       <= RD_START;
                            rd_start_en <= 1'b1;
                            rd_cnt      <= 16'd0;
                            match_cnt   <= 16'd0;
                            state_cnt   <= 24'd0;
                        end else if (timeout_hit) begin
                            state      <= DONE;
                            test_done  <= 1'b1;
                            error_flag <= 1'b1;
                            state_cnt  <= 24'd0;
                        end
                    end

                    RD_START: begin
                        state        <= RD_WAIT;
                        rd_cnt       <= 16'd0;
                        match_cnt    <= 16'd0;
                        rd_busy_seen <= 1'b0;
                        state_cnt    <= 24'd0;
                    end

                    RD_WAIT: begin
                        if (rd_accept) begin
                            rd_cnt <= rd_cnt + 16'd1;
                            if (rd_val_data == rd_cnt) begin
                                match_cnt <= match_cnt + 16'd1;
                            end
                        end
                        if (rd_busy) begin
                            rd_busy_seen <= 1'b1;
                        end
                        if (rd_busy_seen && !rd_busy) begin
                            state     <= CHECK;
                            state_cnt <= 24'd0;
                        end else if (timeout_hit) begin
                            state      <= DONE;
                            test_done  <= 1'b1;
                            error_flag <= 1'b1;
                            state_cnt  <= 24'd0;
                        end
                    end

                    CHECK: begin
                        // Pass only if a full sector came back and every word matched.
                        state      <= DONE;
                        test_done  <= 1'b1;
                        error_flag <= (match_cnt != sec_words_ext) ||
                                      (rd_cnt != sec_words_ext);
                        state_cnt  <= 24'd0;
                    end

                    DONE: begin
                        // Result held; only init_done falling or reset leaves this state.
                        state <= DONE;
                    end

                    default: begin
                        state     <= IDLE;
                        state_cnt <= 24'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sd_data_gen.sv
// Bench for sd_data_gen: plays the SD write and read controllers, predicts the
// pass/fail verdict of each test from the returned words, and compares through
// a result queue consumed by an independent monitor. A second instance with a
// short timeout exercises the watchdog path.
module tb_sd_data_gen;

    localparam int SEC = 256;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        init_done;
    logic        wr_req;
    logic        wr_busy;
    logic        rd_busy;
    logic        rd_val_en;
    logic [15:0] rd_val_data;
    logic        wr_start_en;
    logic        rd_start_en;
    logic        test_done;
    logic        error_flag;
    logic [31:0] wr_sec_addr;
    logic [31:0] rd_sec_addr;
    logic [15:0] wr_data;

    // Timeout instance: its write controller never answers.
    logic        t_init;
    logic        t_zero;
    logic [15:0] t_zero16;
    logic        t_wr_start_en;
    logic        t_rd_start_en;
    logic        t_test_done;
    logic        t_error_flag;
    logic [31:0] t_wr_sec_addr;
    logic [31:0] t_rd_sec_addr;
    logic [15:0] t_wr_data;

    sd_data_gen #(
        .TEST_SEC_ADDR(32'd2000),
        .SEC_WORDS    (9'd256),
        .TIMEOUT_CYC  (24'd2000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .init_done  (init_done),
        .wr_start_en(wr_start_en),
        .wr_sec_addr(wr_sec_addr),
        .wr_req     (wr_req),
        .wr_data    (wr_data),
        .wr_busy    (wr_busy),
        .rd_start_en(rd_start_en),
        .rd_sec_addr(rd_sec_addr),
        .rd_busy    (rd_busy),
        .rd_val_en  (rd_val_en),
        .rd_val_data(rd_val_data),
        .test_done  (test_done),
        .error_flag (error_flag)
    );

    sd_data_gen #(
        .TEST_SEC_ADDR(32'd2000),
        .SEC_WORDS    (9'd256),
        .TIMEOUT_CYC  (24'd100)
    ) dut_to (
        .clk        (clk),
        .rst_n      (rst_n),
        .init_done  (t_init),
        .wr_start_en(t_wr_start_en),
        .wr_sec_addr(t_wr_sec_addr),
        .wr_req     (t_zero),
        .wr_data    (t_wr_data),
        .wr_busy    (t_zero),
        .rd_start_en(t_rd_start_en),
        .rd_sec_addr(t_rd_sec_addr),
        .rd_busy    (t_zero),
        .rd_val_en  (t_zero),
        .rd_val_data(t_zero16),
        .test_done  (t_test_done),
        .error_flag (t_error_flag)
    );

    int errors = 0;
    int checks = 0;

    bit exp_q[$];        // predicted error_flag per completed test
    int wr_pulses  = 0;
    int rd_pulses  = 0;
    int overlap    = 0;
    int long_pulse = 0;
    bit prev_wr    = 1'b0;
    bit prev_rd    = 1'b0;
    bit prev_done  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: counts start pulses and scores each verdict as it appears.
    initial begin
        bit e;
        forever begin
            @(negedge clk);
            if (wr_start_en && rd_start_en) overlap++;
            if (wr_start_en && prev_wr) long_pulse++;
            if (rd_start_en && prev_rd) long_pulse++;
            if (!init_done || !rst_n) begin
                wr_pulses = 0;
                rd_pulses = 0;
            end else begin
                if (wr_start_en) wr_pulses++;
                if (rd_start_en) rd_pulses++;
            end
            if (test_done && !prev_done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected test_done", 32'(test_done), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("error_flag verdict", 32'(error_flag), 32'(e));
                    check("wr_start_en pulses per test", 32'(wr_pulses), 32'd1);
                    check("rd_start_en pulses per test", 32'(rd_pulses), 32'd1);
                end
            end
            prev_wr   = wr_start_en;
            prev_rd   = rd_start_en;
            prev_done = test_done;
        end
    end

    // Wait (bounded) for a start pulse on the main instance.
    task automatic wait_start(input bit rd, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rd ? rd_start_en : wr_start_en) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full test: write model, card model, read model. abort_at >= 0 drops
    // init_done just before that read word is delivered.
    task automatic run_test(input int n_read, input int bad_idx,
                            input logic [15:0] bad_val, input int abort_at);
        logic [15:0] sector [SEC];
        logic [15:0] resp[$];
        logic [15:0] d;
        bit          ok;
        bit          exp_err;
        int          bad_words;

        step();
        init_done = 1'b1;
        wait_start(1'b0, ok);
        check("wr_start_en after init_done rise", 32'(ok), 32'd1);
        if (!ok) begin
            init_done = 1'b0;
            return;
        end

        // Write controller: goes busy, takes SEC words at random pace, goes idle.
        step();
        repeat ($urandom_range(0, 2)) step();
        wr_busy = 1'b1;
        for (int i = 0; i < SEC; i++) begin
            repeat ($urandom_range(0, 1)) step();
            wr_req = 1'b1;
            @(negedge clk);
            sector[i] = wr_data;
            step();
            wr_req = 1'b0;
        end
        repeat ($urandom_range(1, 3)) step();
        wr_busy = 1'b0;

        bad_words = 0;
        for (int i = 0; i < SEC; i++) begin
            if (sector[i] !== 16'(i)) bad_words++;
        end
        check("written sector words out of sequence", 32'(bad_words), 32'd0);

        // Card returns what was stored, with an optional corrupted word.
        // A test passes only if at least a full sector arrives and word i equals i.
        exp_err = (n_read < SEC);
        for (int i = 0; i < n_read; i++) begin
            d = (i < SEC) ? sector[i] : 16'($urandom);
            if (i == bad_idx) d = bad_val;
            if ((i < SEC) && (d !== 16'(i))) exp_err = 1'b1;
            resp.push_back(d);
        end
        if (abort_at < 0) exp_q.push_back(exp_err);

        wait_start(1'b1, ok);
        check("rd_start_en after write done", 32'(ok), 32'd1);
        if (!ok) begin
            init_done = 1'b0;
            return;
        end

        step();
        rd_busy = 1'b1;
        for (int i = 0; i < n_read; i++) begin
            if (i == abort_at) begin
                init_done = 1'b0;
                @(posedge clk);
                @(negedge clk);
                check("abort clears test_done/error_flag/wr_data",
                      32'({test_done, error_flag, wr_data}), 32'd0);
                step();
                rd_busy = 1'b0;
                return;
            end
            repeat ($urandom_range(0, 1)) step();
            rd_val_en   = 1'b1;
            rd_val_data = resp[i];
            step();
            rd_val_en = 1'b0;
        end
        repeat ($urandom_range(1, 2)) step();
        rd_busy = 1'b0;

        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (test_done) begin
                ok = 1'b1;
                break;
            end
        end
        check("test_done reached after read", 32'(ok), 32'd1);
        repeat (5) @(negedge clk);
        check("DONE holds test_done", 32'(test_done), 32'd1);
        check("DONE holds error_flag", 32'(error_flag), 32'(exp_err));

        step();
        init_done = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("init_done fall clears result", 32'({test_done, error_flag}), 32'd0);
        step();
    endtask

    // Reset pulsed in the middle of a write.
    task automatic reset_mid_write();
        bit ok;
        int pulses;
        step();
        init_done = 1'b1;
        wait_start(1'b0, ok);
        check("wr_start_en before reset test", 32'(ok), 32'd1);
        step();
        wr_busy = 1'b1;
        repeat (10) begin
            wr_req = 1'b1;
            step();
        end
        wr_req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async reset clears outputs mid-write",
              32'({wr_start_en, rd_start_en, test_done, error_flag, wr_data}), 32'd0);
        init_done = 1'b0;
        wr_busy   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            pulses += int'(wr_start_en) + int'(rd_start_en);
        end
        check("no start pulse after reset without init edge", 32'(pulses), 32'd0);
    endtask

    // Watchdog instance: write controller never goes busy.
    task automatic timeout_test();
        bit ok;
        bit done;
        int cyc;
        int rdp;
        step();
        t_init = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (t_wr_start_en) begin
                ok = 1'b1;
                break;
            end
        end
        check("timeout: wr_start_en seen", 32'(ok), 32'd1);
        cyc  = 0;
        rdp  = 0;
        done = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            cyc++;
            rdp += int'(t_rd_start_en);
            if (t_test_done) begin
                done = 1'b1;
                break;
            end
        end
        check("timeout: DONE reached", 32'(done), 32'd1);
        check("timeout: cycles to DONE within 100..101", 32'((cyc >= 100) && (cyc <= 101)), 32'd1);
        check("timeout: error_flag", 32'(t_error_flag), 32'd1);
        check("timeout: rd_start_en pulses", 32'(rdp), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          bad;
        logic [15:0] val;

        rst_n       = 1'b0;
        init_done   = 1'b0;
        wr_req      = 1'b0;
        wr_busy     = 1'b0;
        rd_busy     = 1'b0;
        rd_val_en   = 1'b0;
        rd_val_data = 16'd0;
        t_init      = 1'b0;
        t_zero      = 1'b0;
        t_zero16    = 16'd0;

        repeat (3) @(posedge clk);
        #1;
        check("reset values of outputs",
              32'({wr_start_en, rd_start_en, test_done, error_flag, wr_data}), 32'd0);
        check("wr_sec_addr", wr_sec_addr, 32'd2000);
        check("rd_sec_addr", rd_sec_addr, 32'd2000);
        rst_n = 1'b1;

        run_test(SEC, -1, 16'h0000, -1);   // clean pass
        run_test(SEC, 37, 16'h0000, -1);   // word 37 corrupted
        run_test(255, -1, 16'h0000, -1);   // short read
        run_test(257, -1, 16'h0000, -1);   // one extra pulse ignored
        run_test(SEC, -1, 16'h0000, 100);  // abort during read
        run_test(SEC, -1, 16'h0000, -1);   // fresh test after abort
        reset_mid_write();
        run_test(SEC, -1, 16'h0000, -1);   // fresh test after reset

        for (int k = 0; k < 3; k++) begin
            n   = int'($urandom_range(254, 258));
            bad = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, SEC - 1)) : -1;
            val = 16'($urandom);
            run_test(n, bad, val, -1);
        end

        timeout_test();

        repeat (5) @(negedge clk);
        check("verdicts still pending", 32'(exp_q.size()), 32'd0);
        check("cycles with both start pulses", 32'(overlap), 32'd0);
        check("start pulses longer than one cycle", 32'(long_pulse), 32'd0);
        check("wr_sec_addr at end", wr_sec_addr, 32'd2000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
